// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction fetch: next-PC selection for
// sequential/branch/jump/call/return flow plus a circular return-address stack.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4,
    parameter int          RAS_PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_offset,
    input  logic                 jump,
    input  logic [31:0]          jump_target,
    input  logic                 call,
    input  logic [31:0]          call_target,
    input  logic                 ret,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 halted,
    output logic [RAS_PTR_W:0]   ras_count,
    output logic                 ras_overflow,
    output logic                 ras_underflow,
    output logic                 misalign
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t                r_state;
    logic [31:0]           r_pc;
    logic [31:0]           r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0]  r_ptr;
    logic [RAS_PTR_W:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_misalign;

    logic [31:0]           w_pc_plus4;
    logic [31:0]           w_branch_target;
    logic [31:0]           w_pop_value;
    logic [RAS_PTR_W-1:0]  w_top_ptr;
    logic                  w_advance;
    logic                  w_push;
    logic                  w_ras_full;

    // r_ptr names the next free slot; the top entry sits one below it.
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {branch_offset[29:0], 2'b00};
    assign w_top_ptr       = r_ptr - RAS_PTR_W'(1);
    assign w_pop_value     = r_ras[w_top_ptr];
    assign w_advance       = (r_state == ST_RUN) && !halt && !stall;
    assign w_push          = w_advance && !ret && call;
    assign w_ras_full      = (r_count == (RAS_PTR_W+1)'(RAS_DEPTH));

    // Return-address storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_pc_plus4;
        end
    end

    // Control state, PC, stack pointer/count and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_HALT;
                    end else if (stall) begin
                        r_state <= ST_RUN;
                    end else if (ret) begin
                        if (r_count != '0) begin
                            r_pc       <= {w_pop_value[31:2], 2'b00};
                            r_misalign <= r_misalign | (|w_pop_value[1:0]);
                            r_ptr      <= w_top_ptr;
                            r_count    <= r_count - (RAS_PTR_W+1)'(1);
                        end else begin
                            r_pc        <= w_pc_plus4;
                            r_underflow <= 1'b1;
                        end
                    end else if (call) begin
                        r_pc       <= {call_target[31:2], 2'b00};
                        r_misalign <= r_misalign | (|call_target[1:0]);
                        r_ptr      <= r_ptr + RAS_PTR_W'(1);
                        // A full stack overwrites its oldest entry and stays full.
                        if (w_ras_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + (RAS_PTR_W+1)'(1);
                        end
                    end else if (jump) begin
                        r_pc       <= {jump_target[31:2], 2'b00};
                        r_misalign <= r_misalign | (|jump_target[1:0]);
                    end else if (branch_taken) begin
                        r_pc       <= {w_branch_target[31:2], 2'b00};
                        r_misalign <= r_misalign | (|w_branch_target[1:0]);
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign halted        = (r_state == ST_HALT);
    assign ras_count     = r_count;
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;
    assign misalign      = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes reference-model results,
// a falling-edge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        stall, halt, branch_taken, jump, call, ret;
    logic [31:0] branch_offset, jump_target, call_target;
    logic [31:0] pc, pc_plus4;
    logic        halted, ras_overflow, ras_underflow, misalign;
    logic [2:0]  ras_count;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .RAS_DEPTH(DEPTH), .RAS_PTR_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .call(call), .call_target(call_target), .ret(ret),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        bit          h, ovf, unf, mis;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: architectural view, return addresses newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_h, m_ovf, m_unf, m_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ras.delete(); m_h = 0; m_ovf = 0; m_unf = 0; m_mis = 0;
    endtask

    task automatic model_take(input logic [31:0] t);
        if (t[1:0] != 2'b00) m_mis = 1;
        m_pc = {t[31:2], 2'b00};
    endtask

    // Drive one cycle of requests, advance the model, queue the expectation.
    task automatic step(input bit st, input bit hl, input bit br, input logic [31:0] bo,
                        input bit jp, input logic [31:0] jt, input bit cl,
                        input logic [31:0] ct, input bit rt);
        exp_t e;
        stall = st; halt = hl; branch_taken = br; branch_offset = bo;
        jump = jp; jump_target = jt; call = cl; call_target = ct; ret = rt;
        if (m_h) begin
        end else if (hl) begin
            m_h = 1;
        end else if (st) begin
        end else if (rt) begin
            if (m_ras.size() > 0) model_take(m_ras.pop_back());
            else begin m_pc = m_pc + 32'd4; m_unf = 1; end
        end else if (cl) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1; end
            model_take(ct);
        end else if (jp) begin
            model_take(jt);
        end else if (br) begin
            model_take(m_pc + 32'd4 + (bo << 2));
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.cnt = m_ras.size(); e.h = m_h;
        e.ovf = m_ovf; e.unf = m_unf; e.mis = m_mis;
        sb.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle();    step(0,0,0,32'h0,0,32'h0,0,32'h0,0); endtask
    task automatic do_jump(input logic [31:0] t); step(0,0,0,32'h0,1,t,0,32'h0,0); endtask
    task automatic do_call(input logic [31:0] t); step(0,0,0,32'h0,0,32'h0,1,t,0); endtask
    task automatic do_ret();  step(0,0,0,32'h0,0,32'h0,0,32'h0,1); endtask
    task automatic do_br(input logic [31:0] o);   step(0,0,1,o,0,32'h0,0,32'h0,0); endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic async_reset(input bit check);
        rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_pc", pc, 32'h0);
            chk("rst_count", {29'h0, ras_count}, 32'h0);
            chk("rst_mis", {31'h0, misalign}, 32'h0);
            chk("rst_halted", {31'h0, halted}, 32'h0);
        end
        model_reset();
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Monitor: the DUT presents a new state every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pc", pc, mon_e.pc);
            chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
            chk("ras_count", {29'h0, ras_count}, mon_e.cnt);
            chk("halted", {31'h0, halted}, {31'h0, mon_e.h});
            chk("ras_overflow", {31'h0, ras_overflow}, {31'h0, mon_e.ovf});
            chk("ras_underflow", {31'h0, ras_underflow}, {31'h0, mon_e.unf});
            chk("misalign", {31'h0, misalign}, {31'h0, mon_e.mis});
        end
    end

    initial begin
        logic [31:0] t1, t2, t3;
        int          halted_cycles;
        rst = 1'b1; stall = 0; halt = 0; branch_taken = 0; branch_offset = 32'h0;
        jump = 0; jump_target = 32'h0; call = 0; call_target = 32'h0; ret = 0;
        model_reset();
        @(negedge clk); #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_count", {29'h0, ras_count}, 32'h0);
        chk("reset_halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;

        // Sequential and wrap
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("seq_pc", pc, 32'(i * 4));
        end
        do_jump(32'hFFFF_FFF8);
        idle(); chk("wrap_fffc", pc, 32'hFFFF_FFFC);
        idle(); chk("wrap_zero", pc, 32'h0000_0000);

        // Branch
        do_jump(32'h20);
        do_br(32'hFFFF_FFFD); chk("branch_neg", pc, 32'h18);
        do_br(32'h2);         chk("branch_pos", pc, 32'h24);

        // Call/return nesting and underflow
        do_jump(32'h10);
        do_call(32'h40);
        do_call(32'h80);
        chk("nest_count", {29'h0, ras_count}, 32'd2);
        do_ret(); chk("ret1", pc, 32'h44);
        do_ret(); chk("ret2", pc, 32'h14);
        chk("nest_empty", {29'h0, ras_count}, 32'd0);
        do_ret(); chk("ret_under_pc", pc, 32'h18);
        chk("underflow", {31'h0, ras_underflow}, 32'd1);

        // Overflow: five calls, the four newest return addresses survive
        for (int i = 1; i <= 5; i++) do_call(32'(i * 32'h100));
        chk("ovf_count", {29'h0, ras_count}, 32'd4);
        chk("overflow", {31'h0, ras_overflow}, 32'd1);
        for (int i = 4; i >= 1; i--) begin
            do_ret();
            chk("ovf_ret", pc, 32'(i * 32'h100 + 4));
        end

        // Stall drops a jump; ret beats call and jump with no push
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,32'h0,1,32'h0000_0800,0,32'h0,0);
            chk("stall_hold", pc, 32'h104);
        end
        do_call(32'h600);
        step(0,0,0,32'h0,1,32'h800,1,32'h700,1);
        chk("prio_ret", pc, 32'h108);
        chk("prio_nopush", {29'h0, ras_count}, 32'd0);

        // Halt taken even under stall, then frozen
        step(1,1,0,32'h0,0,32'h0,0,32'h0,0);
        chk("halt_enter", {31'h0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step($urandom_range(0,1), 0, 1, $urandom, 1, $urandom, 1, $urandom, $urandom_range(0,1));
            chk("halt_frozen", pc, 32'h108);
        end

        // Asynchronous reset mid-operation
        async_reset(0);
        do_jump(32'h101);
        do_call(32'h40); do_call(32'h80); do_call(32'hC0);
        chk("pre_rst_count", {29'h0, ras_count}, 32'd3);
        chk("pre_rst_mis", {31'h0, misalign}, 32'd1);
        async_reset(1);
        do_jump(32'h33);
        chk("post_rst_pc", pc, 32'h30);
        chk("post_rst_mis", {31'h0, misalign}, 32'd1);

        // Randomized traffic against the model
        halted_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            t1 = $urandom; t2 = $urandom; t3 = $urandom;
            if ($urandom_range(0,3) != 0) t1[1:0] = 2'b00;
            if ($urandom_range(0,3) != 0) t2[1:0] = 2'b00;
            if ($urandom_range(0,1) != 0) t3 = $urandom_range(0,64) - 32;
            step($urandom_range(0,5) == 0, $urandom_range(0,79) == 0,
                 $urandom_range(0,3) == 0, t3,
                 $urandom_range(0,5) == 0, t1,
                 $urandom_range(0,3) == 0, t2,
                 $urandom_range(0,3) == 0);
            if (m_h) halted_cycles++;
            if (halted_cycles > 8 || $urandom_range(0,149) == 0) begin
                async_reset(1);
                halted_cycles = 0;
            end
        end

        @(negedge clk); #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of instruction fetch. Holds the architectural PC and drives it to the fetch stage every cycle.
- Computes the next PC from sequential, branch, jump, call and return requests.
- Keeps a small circular return-address stack (RAS) for call/return.
- The instruction ROM reads on the falling edge of clk, so the PC changes only on the rising edge and is stable for the following half-cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address entries. Must be a power of two, 2..16.
- RAS_PTR_W, 2, log2(RAS_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze PC and RAS this cycle.
- halt  in  1  enter HALT state.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  32  signed word offset, relative to pc+4.
- jump  in  1  unconditional absolute jump.
- jump_target  in  32  absolute byte address.
- call  in  1  jump to call_target and push pc+4.
- call_target  in  32  absolute byte address.
- ret  in  1  pop RAS and jump to the popped address.
- pc  out  32  current PC, to fetch stage.
- pc_plus4  out  32  pc+4, combinational.
- halted  out  1  high while in HALT.
- ras_count  out  RAS_PTR_W+1  valid RAS entries, 0..RAS_DEPTH.
- ras_overflow  out  1  sticky: a call was made with the RAS full.
- ras_underflow  out  1  sticky: a ret was made with the RAS empty.
- misalign  out  1  sticky: a target had non-zero bits [1:0].

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - pc=RESET_PC, state=RUN, halted=0.
  - RAS pointer and count cleared; all sticky flags cleared.
  - RAS entry contents are don't-care.
- States: RUN, HALT.
  - RUN -> HALT on a rising edge with halt=1, including when stall=1. pc is not updated on that edge.
  - HALT is left only by reset. In HALT, pc, RAS and flags are frozen and all requests are ignored.
  - halted=1 from the edge that enters HALT.
- In RUN with stall=1 and halt=0: pc, RAS, ras_count and flags hold; requests are dropped, not queued.
- In RUN with stall=0, exactly one action per edge, in this priority order:
  1. ret
  2. call
  3. jump
  4. branch_taken
  5. sequential
- ret:
  - If ras_count>0: pc <= top entry; pointer decrements; ras_count-1.
  - If ras_count==0: pc <= pc+4; ras_underflow <= 1.
- call:
  - pc <= call_target; push pc+4; ras_count = min(ras_count+1, RAS_DEPTH).
  - Full RAS: the oldest entry is overwritten (pointer wraps modulo RAS_DEPTH), ras_count stays at RAS_DEPTH, ras_overflow <= 1.
- jump: pc <= jump_target.
- branch: pc <= pc + 4 + (branch_offset<<2). 32-bit arithmetic, carries discarded.
- Sequential: pc <= pc+4, wrapping 32'hFFFF_FFFC -> 0.
- Targets (call_target, jump_target, computed branch target, popped value) are written with bits [1:0] forced to 0. misalign <= 1 if the raw target had non-zero [1:0].
- Latency: a request sampled on edge N gives the new pc after edge N. The fetch stage reads it on the next falling edge.
- Lower-priority requests asserted together with a higher one are discarded silently. Call and ret together: ret wins, no push.
- pc_plus4 is always pc+4 (combinational), including in HALT.

Test Plan:
1. Sequential and wrap: reset, run 5 cycles -> pc = 0,4,8,12,16,20. Preload via jump to 32'hFFFF_FFF8 -> next pcs FFFF_FFFC, 0000_0000.
2. Branch: at pc=0x20, branch_taken with offset=-3 -> pc=0x18. With offset=+2 from pc=0x18 -> pc=0x24.
3. Call/return nesting:
   - call 0x40 at pc=0x10, then call 0x80 at 0x40 -> ras_count=2.
   - ret -> pc=0x44; ret -> pc=0x14; ras_count=0.
   - A third ret -> pc=0x18, ras_underflow=1.
4. RAS overflow: 5 calls with RAS_DEPTH=4 -> ras_count=4, ras_overflow=1. Then 4 rets return the 4 newest return addresses, newest first.
5. Stall/priority/halt:
   - stall held 3 cycles with jump asserted -> pc unchanged, jump dropped.
   - ret+call+jump together -> ret taken, no push.
   - halt with stall=1 -> halted=1, pc frozen for 10 cycles.
6. Async reset mid-operation: assert rst between edges while ras_count=3, misalign=1 -> pc=RESET_PC, ras_count=0, misalign=0 immediately, with no clock edge needed. Jump to 0x33 after release -> pc=0x30, misalign=1.
